tick_gen: RTL and testbench
===========================

// Module: tick_gen
//
// PURPOSE
//   Programmable clock-enable / tick generator: emits a one-cycle pulse every
//   (div+1) clk cycles, periodic or one-shot, with runtime divisor reload via a
//   valid/ready handshake and a wrapping tick counter. Drives timing enables for
//   SD-card bus sequencing and slow peripheral strobes, all in a single clk domain.
//
// PARAMETERS
//   WIDTH        16   width of divisor and internal phase counter
//   CNT_W        8    width of o_tick_cnt
//   DEFAULT_DIV  15   divisor loaded at reset (period 16 cycles)
//
// PORTS
//   clk          in   1      system clock; all logic on posedge
//   rst          in   1      reset, synchronous, active-high
//   i_div_valid  in   1      new divisor offered
//   i_div_data   in   WIDTH  new divisor value (period = value+1)
//   o_div_ready  out  1      divisor load accepted when valid & ready
//   i_start      in   1      start/retrigger pulse
//   i_stop       in   1      stop pulse
//   i_mode       in   1      0 = periodic, 1 = one-shot; sampled with i_start
//   o_tick       out  1      one-cycle tick pulse (registered)
//   o_busy       out  1      1 while in RUN
//   o_tick_cnt   out  CNT_W  ticks emitted since reset, wraps
//   o_clk_out    out  1      square wave, present only with TICK_CLKOUT_EN
//
// BEHAVIOUR
//   - Reset (rst high at a posedge): state IDLE, cnt=0, div_r=DEFAULT_DIV,
//     shadow pending=0, mode_r=0, o_tick=0, o_busy=0, o_tick_cnt=0,
//     o_div_ready=1, o_clk_out=0. Reset mid-RUN aborts with no tick.
//   - States: IDLE, RUN. o_busy = (state==RUN), registered.
//   - IDLE: i_start -> RUN, cnt<=0, mode_r<=i_mode. Otherwise hold; o_tick=0.
//   - RUN, each edge: if cnt==div_r: o_tick<=1, cnt<=0, o_tick_cnt++ (wraps at
//     2^CNT_W-1 -> 0), apply pending divisor, and if mode_r=1 -> IDLE.
//     Else cnt<=cnt+1, o_tick<=0.
//   - Latency: start sampled at edge T -> o_tick high in cycle after edge
//     T+div_r+1; periodic ticks every div_r+1 cycles. div_r=0 -> tick every cycle.
//   - Stop: i_stop in RUN -> IDLE, cnt<=0, o_tick<=0 that edge even if cnt==div_r.
//   - Simultaneous start & stop: stop wins (IDLE, no restart).
//   - Start while RUN (no stop): retrigger; cnt<=0, mode_r re-sampled, no tick.
//   - Divisor handshake: transfer when i_div_valid & o_div_ready.
//     IDLE: div_r<=i_div_data next edge; o_div_ready stays 1.
//     RUN: value to shadow, pending<=1, o_div_ready<=0; applied to div_r at next
//     tick wrap (or on stop/entry to IDLE); then pending<=0, o_div_ready<=1.
//   - Load and wrap on the same edge in RUN: the old div_r ends this period;
//     new value goes to shadow and applies at the following wrap.
//   - cnt compare is equality on WIDTH bits; cnt never exceeds div_r (shadow
//     updates only at wrap, so no overshoot).
//
// CONFIGURATION
//   TICK_CLKOUT_EN defined: o_clk_out port exists; toggles on every tick in
//     RUN (period 2*(div_r+1), 50% duty); forced to 0 on entry to IDLE and reset.
//   TICK_CLKOUT_EN undefined: o_clk_out port and its logic are absent; all
//     other behaviour identical.
//
// TESTING
//   1 Reset, start periodic, default div 15 -> o_tick every 16 cycles, first
//     16 cycles after start; o_tick_cnt 1,2,3...
//   2 Load div=0 in IDLE, start -> o_tick high every cycle; o_tick_cnt wraps
//     255->0 after 256 ticks (CNT_W=8).
//   3 Periodic div=4, load div=9 mid-period -> o_div_ready low until next
//     tick; period 5 then 10.
//   4 One-shot div=3 -> exactly one tick 4 cycles after start, o_busy drops
//     with tick edge, no further ticks.
//   5 Start+stop same cycle -> stays IDLE; stop at cnt==div_r -> no tick;
//     rst high mid-RUN -> all outputs return to reset values next edge.
//   6 TICK_CLKOUT_EN, div=2 periodic -> o_clk_out period 6, 3 high/3 low;
//     stop -> o_clk_out 0.

Source files
------------

// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - divisor load, control and tick status bundle for tick_gen (o_clk_out only with TICK_CLKOUT_EN)
interface tick_gen_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             i_div_valid;
    logic [WIDTH-1:0] i_div_data;
    logic             o_div_ready;
    logic             i_start;
    logic             i_stop;
    logic             i_mode;
    logic             o_tick;
    logic             o_busy;
    logic [CNT_W-1:0] o_tick_cnt;
`ifdef TICK_CLKOUT_EN
    logic             o_clk_out;

    // Controller side: offers divisors and start/stop, observes ticks
    modport master (
        output i_div_valid, i_div_data, i_start, i_stop, i_mode,
        input  o_div_ready, o_tick, o_busy, o_tick_cnt, o_clk_out
    );

    // Generator side
    modport slave (
        input  i_div_valid, i_div_data, i_start, i_stop, i_mode,
        output o_div_ready, o_tick, o_busy, o_tick_cnt, o_clk_out
    );
`else
    // Controller side: offers divisors and start/stop, observes ticks
    modport master (
        output i_div_valid, i_div_data, i_start, i_stop, i_mode,
        input  o_div_ready, o_tick, o_busy, o_tick_cnt
    );

    // Generator side
    modport slave (
        input  i_div_valid, i_div_data, i_start, i_stop, i_mode,
        output o_div_ready, o_tick, o_busy, o_tick_cnt
    );
`endif
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable periodic/one-shot tick generator; TICK_CLKOUT_EN adds o_clk_out square wave
module tick_gen #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 15
) (
    input  logic        clk,
    input  logic        rst,
    tick_gen_if.slave   bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic             mode_r;
    logic             tick_r;
    logic             busy_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic             div_ready_r;

    logic             load;
    logic             run_stop;
    logic             run_retrig;
    logic             wrap_evt;
    logic             to_idle;

    // A divisor transfer happens whenever the offer meets our ready flag
    assign load       = bus.i_div_valid & div_ready_r;

    // Decode this edge's RUN event; stop outranks retrigger, which outranks the wrap
    assign run_stop   = (state == ST_RUN) & bus.i_stop;
    assign run_retrig = (state == ST_RUN) & ~bus.i_stop & bus.i_start;
    assign wrap_evt   = (state == ST_RUN) & ~bus.i_stop & ~bus.i_start & (cnt == div_r);
    assign to_idle    = run_stop | (wrap_evt & mode_r);

    // Control FSM with phase counter, divisor shadow and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            div_r       <= WIDTH'(DEFAULT_DIV);
            shadow      <= '0;
            pending     <= 1'b0;
            mode_r      <= 1'b0;
            tick_r      <= 1'b0;
            busy_r      <= 1'b0;
            tick_cnt_r  <= '0;
            div_ready_r <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick_r <= 1'b0;
                    // While idle a new divisor takes effect immediately
                    if (load) begin
                        div_r <= bus.i_div_data;
                    end
                    if (bus.i_start && !bus.i_stop) begin
                        state  <= ST_RUN;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                        mode_r <= bus.i_mode;
                    end
                end

                ST_RUN: begin
                    if (wrap_evt) begin
                        tick_r     <= 1'b1;
                        cnt        <= '0;
                        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
                    end else begin
                        tick_r <= 1'b0;
                        cnt    <= (run_stop || run_retrig) ? '0 : cnt + WIDTH'(1);
                    end

                    if (run_retrig) begin
                        mode_r <= bus.i_mode;
                    end

                    if (to_idle) begin
                        state       <= ST_IDLE;
                        busy_r      <= 1'b0;
                        // Leaving RUN flushes the divisor path straight into div_r;
                        // a same-edge load wins since it is newer than any shadow
                        pending     <= 1'b0;
                        div_ready_r <= 1'b1;
                        if (load) begin
                            div_r <= bus.i_div_data;
                        end else if (pending) begin
                            div_r <= shadow;
                        end
                    end else if (wrap_evt && pending) begin
                        // Period boundary: the parked divisor shapes the next period
                        div_r       <= shadow;
                        pending     <= 1'b0;
                        div_ready_r <= 1'b1;
                    end else if (load) begin
                        // Mid-period (or same-edge wrap) load waits for the next wrap
                        shadow      <= bus.i_div_data;
                        pending     <= 1'b1;
                        div_ready_r <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    tick_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tick      = tick_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_tick_cnt  = tick_cnt_r;
    assign bus.o_div_ready = div_ready_r;

`ifdef TICK_CLKOUT_EN
    logic clk_out_r;

    // Square wave toggling on each periodic wrap, parked low whenever RUN ends
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_r <= 1'b0;
        end else if (to_idle) begin
            clk_out_r <= 1'b0;
        end else if (wrap_evt) begin
            clk_out_r <= ~clk_out_r;
        end
    end

    assign bus.o_clk_out = clk_out_r;
`endif
endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - directed bench for tick_gen with a time-stamp reference model
module tb_tick_gen;
    localparam int WIDTH       = 16;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 15;

    logic clk;
    logic rst;

    tick_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    tick_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the absolute edge number at which the next tick is due
    int   e = 0;
    int   m_next;
    bit   m_valid = 0;
    bit   m_run, m_oneshot, m_pend, m_tick, m_clk, m_ld;
    int   m_div, m_shadow, m_cnt;

    always @(posedge clk) begin
        e++;
        m_ld = bus.i_div_valid && !m_pend;
        if (rst) begin
            m_valid = 1; m_run = 0; m_oneshot = 0; m_pend = 0; m_tick = 0;
            m_clk = 0; m_div = DEFAULT_DIV; m_shadow = 0; m_cnt = 0; m_next = 0;
        end else if (m_valid) begin
            if (!m_run) begin
                m_tick = 0;
                if (m_ld) m_div = int'(bus.i_div_data);
                if (bus.i_start && !bus.i_stop) begin
                    m_run = 1; m_oneshot = bus.i_mode; m_next = e + m_div + 1;
                end
            end else if (bus.i_stop) begin
                m_run = 0; m_tick = 0; m_clk = 0;
                if (m_ld) m_div = int'(bus.i_div_data);
                else if (m_pend) m_div = m_shadow;
                m_pend = 0;
            end else if (bus.i_start) begin
                m_tick = 0; m_oneshot = bus.i_mode; m_next = e + m_div + 1;
                if (m_ld) begin m_shadow = int'(bus.i_div_data); m_pend = 1; end
            end else if (e == m_next) begin
                m_tick = 1; m_cnt = (m_cnt + 1) % 256;
                if (m_oneshot) begin
                    m_run = 0; m_clk = 0;
                    if (m_ld) m_div = int'(bus.i_div_data);
                    else if (m_pend) m_div = m_shadow;
                    m_pend = 0;
                end else begin
                    m_clk = !m_clk;
                    if (m_pend) begin m_div = m_shadow; m_pend = 0; end
                    else if (m_ld) begin m_shadow = int'(bus.i_div_data); m_pend = 1; end
                    m_next = e + m_div + 1;
                end
            end else begin
                m_tick = 0;
                if (m_ld) begin m_shadow = int'(bus.i_div_data); m_pend = 1; end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, just after each edge settles
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("tick", 32'(bus.o_tick), 32'(m_tick));
            check("busy", 32'(bus.o_busy), 32'(m_run));
            check("tick_cnt", 32'(bus.o_tick_cnt), 32'(m_cnt));
            check("div_ready", 32'(bus.o_div_ready), 32'(!m_pend));
`ifdef TICK_CLKOUT_EN
            check("clk_out", 32'(bus.o_clk_out), 32'(m_clk));
`endif
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_div(input int v);
        bus.i_div_valid = 1'b1;
        bus.i_div_data  = WIDTH'(v);
        @(negedge clk);
        bus.i_div_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic mode);
        bus.i_start = 1'b1;
        bus.i_mode  = mode;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
    endtask

    // Cycles from the current sample point until o_tick is seen; bounded
    task automatic tick_wait(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tick && n < 300);
    endtask

    int n;
    int cnt_ticks;

    initial begin
        rst = 1'b1;
        bus.i_div_valid = 1'b0;
        bus.i_div_data  = '0;
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_mode      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_tick", 32'(bus.o_tick), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_cnt", 32'(bus.o_tick_cnt), 0);
        check("rst_ready", 32'(bus.o_div_ready), 1);

        // Default divisor, periodic
        pulse_start(1'b0);
        check("t1_busy", 32'(bus.o_busy), 1);
        tick_wait(n);
        check("t1_first_lat", 32'(n), 16);
        check("t1_cnt1", 32'(bus.o_tick_cnt), 1);
        tick_wait(n);
        check("t1_period", 32'(n), 16);
        check("t1_cnt2", 32'(bus.o_tick_cnt), 2);
        pulse_stop();

        // div=0: tick every cycle, counter wrap
        do_reset();
        load_div(0);
        pulse_start(1'b0);
        tick_wait(n);
        check("t2_lat", 32'(n), 1);
        repeat (254) @(negedge clk);
        check("t2_cnt255", 32'(bus.o_tick_cnt), 255);
        check("t2_tick_on", 32'(bus.o_tick), 1);
        @(negedge clk);
        check("t2_wrap0", 32'(bus.o_tick_cnt), 0);
        check("t2_model_wrap", 32'(m_cnt), 0);
        pulse_stop();

        // div=4 then mid-period reload to 9
        do_reset();
        load_div(4);
        pulse_start(1'b0);
        tick_wait(n);
        check("t3_p5", 32'(n), 5);
        @(negedge clk);
        bus.i_div_valid = 1'b1;
        bus.i_div_data  = WIDTH'(9);
        @(negedge clk);
        bus.i_div_valid = 1'b0;
        check("t3_ready_low", 32'(bus.o_div_ready), 0);
        tick_wait(n);
        check("t3_rest_of_p5", 32'(n), 3);
        check("t3_ready_back", 32'(bus.o_div_ready), 1);
        tick_wait(n);
        check("t3_p10a", 32'(n), 10);
        tick_wait(n);
        check("t3_p10b", 32'(n), 10);
        // Loads at assorted phases, including ones colliding with wraps or pending slots
        for (int p = 0; p < 8; p++) begin
            repeat (p + 1) @(negedge clk);
            load_div(p % 5 + 1);
        end
        repeat (40) @(negedge clk);
        pulse_stop();

        // One-shot div=3
        do_reset();
        load_div(3);
        pulse_start(1'b1);
        tick_wait(n);
        check("t4_lat", 32'(n), 4);
        check("t4_busy_drop", 32'(bus.o_busy), 0);
        cnt_ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_tick) cnt_ticks++;
        end
        check("t4_no_more", 32'(cnt_ticks), 0);
        check("t4_cnt", 32'(bus.o_tick_cnt), 1);

        // Start+stop together, stop at terminal count, retrigger, reset mid-RUN
        do_reset();
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        check("t5_ss_idle", 32'(bus.o_busy), 0);
        pulse_start(1'b0);
        repeat (15) @(negedge clk);
        pulse_stop();
        check("t5_stop_notick", 32'(bus.o_tick), 0);
        check("t5_stop_idle", 32'(bus.o_busy), 0);
        check("t5_stop_cnt", 32'(bus.o_tick_cnt), 0);
        pulse_start(1'b0);
        repeat (10) @(negedge clk);
        pulse_start(1'b0);
        tick_wait(n);
        check("t5_retrig_lat", 32'(n), 16);
        repeat (3) @(negedge clk);
        load_div(7);
        check("t5_pend", 32'(bus.o_div_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_tick", 32'(bus.o_tick), 0);
        check("t5_rst_busy", 32'(bus.o_busy), 0);
        check("t5_rst_cnt", 32'(bus.o_tick_cnt), 0);
        check("t5_rst_ready", 32'(bus.o_div_ready), 1);

`ifdef TICK_CLKOUT_EN
        // Square wave at div=2
        do_reset();
        load_div(2);
        pulse_start(1'b0);
        tick_wait(n);
        check("t6_lat", 32'(n), 3);
        check("t6_hi", 32'(bus.o_clk_out), 1);
        repeat (3) @(negedge clk);
        check("t6_lo", 32'(bus.o_clk_out), 0);
        repeat (3) @(negedge clk);
        check("t6_hi2", 32'(bus.o_clk_out), 1);
        pulse_stop();
        check("t6_stop_lo", 32'(bus.o_clk_out), 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
